// File: rtl/encode_pkg.sv
// Shared types and constants for the encode-core controller.
package encode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_START,
    ST_WAIT
  } state_e;

  localparam int MSG_BITS    = 256;
  localparam int BYTE_W      = 8;
  localparam int DEF_TIMEOUT = 512;

endpackage

// File: rtl/m_encode_ctrl_serializer.sv
// Byte-to-bit shifter: holds one byte and presents it LSB first, one bit per cycle.
module msg_serializer
  import encode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_bit,
  output logic              o_full,
  output logic              o_last
);

  logic [BYTE_W-1:0] r_sh;
  logic [2:0]        r_idx;
  logic              r_full;

  // A load on the last-bit cycle replaces the byte seamlessly, giving 8 cycles per byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh   <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_sh   <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_byte;
      r_idx  <= '0;
      r_full <= 1'b1;
    end else if (r_full) begin
      r_sh  <= r_sh >> 1;
      r_idx <= r_idx + 3'd1;
      if (r_idx == 3'd7) r_full <= 1'b0;
    end
  end

  assign o_bit  = r_sh[0];
  assign o_full = r_full;
  assign o_last = r_full && (r_idx == 3'd7);

endmodule

// File: rtl/m_encode_ctrl.sv
// Sequencer for the encode core: clear, serial message load, start, then wait
// for the compute flag to complete or time out.
module m_encode_ctrl
  import encode_pkg::*;
#(
  parameter int MSG_BYTES = MSG_BITS / BYTE_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_req,
  input  logic              msg_valid,
  input  logic [BYTE_W-1:0] msg_byte,
  output logic              msg_ready,
  output logic              enc_reset,
  output logic              enc_load,
  output logic              enc_m_in,
  output logic              enc_start,
  input  logic              enc_compute,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int            CW          = $clog2(MSG_BYTES + 1);
  localparam int            TW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_BYTES    = CW'(MSG_BYTES);
  localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT - 1);

  state_e        r_state, w_next;
  logic [CW-1:0] r_byte_cnt;
  logic [TW-1:0] r_wait_cnt;
  logic          r_seen, r_done, r_err;
  logic          w_start_job, w_accept, w_bytes_left, w_complete, w_tmo;
  logic          w_sh_bit, w_sh_full, w_sh_last;

  assign w_start_job  = (r_state == ST_IDLE) && job_req;
  assign w_accept     = msg_valid && msg_ready;
  assign w_bytes_left = (r_byte_cnt != LP_BYTES);
  assign w_complete   = r_seen && !enc_compute;
  assign w_tmo        = (r_wait_cnt == LP_TMO_LAST);

  msg_serializer u_ser (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start_job),
    .i_load (w_accept),
    .i_byte (msg_byte),
    .o_bit  (w_sh_bit),
    .o_full (w_sh_full),
    .o_last (w_sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (job_req) w_next = ST_CLR;
      ST_CLR:   w_next = ST_LOAD;
      ST_LOAD:  if (!w_bytes_left && w_sh_last) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (w_complete || w_tmo) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    enc_reset = 1'b0;
    enc_load  = 1'b0;
    enc_m_in  = 1'b0;
    enc_start = 1'b0;
    busy      = (r_state != ST_IDLE);
    done      = r_done;
    err       = r_err;
    case (r_state)
      ST_CLR:   enc_reset = 1'b1;
      ST_LOAD: begin
        msg_ready = w_bytes_left && (!w_sh_full || w_sh_last);
        enc_load  = w_sh_full;
        enc_m_in  = w_sh_full && w_sh_bit;
      end
      ST_START: enc_start = 1'b1;
      default: ;
    endcase
  end

  // done is registered so it lands on the first IDLE cycle after completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_wait_cnt <= '0;
      r_seen     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_job) begin
        r_byte_cnt <= '0;
        r_err      <= 1'b0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + CW'(1);
      end
      if (r_state == ST_WAIT) begin
        r_seen     <= r_seen | enc_compute;
        r_wait_cnt <= r_wait_cnt + TW'(1);
        if (w_complete)  r_done <= 1'b1;
        else if (w_tmo)  r_err  <= 1'b1;
      end else begin
        r_seen     <= 1'b0;
        r_wait_cnt <= '0;
      end
    end
  end

endmodule
